alu_seq: RTL and testbench

- Parametrised successor to the core integer ALU.
- Operand width is generic. Single-cycle ops (MOV/ADD/SUB/SHR/SHL/XOR/AND/OR) complete in one enabled cycle.
- MUL (shift-add) and DIV (restoring) are iterative multi-cycle engines, so no wide combinational multiplier or divider is inferred.
- Adds a start/busy/done handshake, a divide-by-zero flag, and zero/carry flags. Sits between the operand-fetch stage and the ALU_RESULTS write-back stage.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq_divider.sv | 69 ++++++
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared command codes and FSM state encodings for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] CMD_MOV = 4'h0;
  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_SHR = 4'h3;
  localparam logic [3:0] CMD_SHL = 4'h4;
  localparam logic [3:0] CMD_XOR = 4'h5;
  localparam logic [3:0] CMD_AND = 4'h6;
  localparam logic [3:0] CMD_OR  = 4'h7;
  localparam logic [3:0] CMD_MUL = 4'h8;
  localparam logic [3:0] CMD_DIV = 4'h9;

  typedef enum logic [1:0] {
    ALU_SEQ_IDLE = 2'd0,
    ALU_SEQ_MUL  = 2'd1,
    ALU_SEQ_DIV  = 2'd2
  } alu_seq_state_t;

  // Codes MOV..OR finish in the acceptance cycle.
  function automatic logic is_single_cycle(input logic [3:0] cmd);
    return (cmd <= CMD_OR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between operand fetch and result write-back.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] src1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dst;
  logic [WIDTH-1:0] dst_h;
  logic             flag_z;
  logic             flag_c;
  logic             div_zero;

  modport master (
    output start, cmd, src0, src1,
    input  busy, done, dst, dst_h, flag_z, flag_c, div_zero
  );

  modport slave (
    input  start, cmd, src0, src1,
    output busy, done, dst, dst_h, flag_z, flag_c, div_zero
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Restoring divider: one quotient bit per enabled cycle, WIDTH cycles per divide.
// done is a combinational strobe on the final step; quotient/remainder are valid while it is high.
module alu_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_nxt;

  // rem < dvs always holds, so the shifted partial fits WIDTH+1 bits and
  // the top bit of the trial subtraction is the borrow.
  always_comb begin
    partial = {rem, quo[WIDTH-1]};
    diff    = partial - {1'b0, dvs};
    quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
    rem_nxt = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  assign done      = en & running & (cnt == CNT_W'(1));
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (en) begin
      if (start) begin
        running <= 1'b1;
        cnt     <= CNT_W'(WIDTH);
      end else if (running) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) running <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (start) begin
        quo <= dividend;
        rem <= '0;
        dvs <= divisor;
      end else if (running) begin
        quo <= quo_nxt;
        rem <= rem_nxt;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential integer ALU: single-cycle logic/arith ops, iterative shift-add MUL
// and restoring DIV, with start/busy/done handshake and zero/carry/div-zero flags.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clk_oe,
  alu_seq_if.slave bus
);
  import alu_seq_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  alu_seq_state_t     state;
  alu_seq_state_t     state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_sum;
  logic               mul_last;
  logic [2*WIDTH-1:0] sc_res;
  logic               div_start;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               done_flag;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   res_hi;
  logic               zero;
  logic               carry;
  logic               dz;
  logic               idle_start;

  function automatic logic [2*WIDTH-1:0] single_op(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic             big;
    logic [WIDTH-1:0] lo;
    big = (|b[WIDTH-1:CNT_W]) || (b[CNT_W-1:0] >= CNT_W'(WIDTH));
    lo  = '0;
    single_op = '0;
    case (op)
      CMD_MOV: single_op = {b, a};
      CMD_ADD: single_op = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
      CMD_SUB: single_op = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
      CMD_SHR: begin
        lo = big ? '0 : (a >> b);
        single_op = {{WIDTH{1'b0}}, lo};
      end
      CMD_SHL: begin
        lo = big ? '0 : (a << b);
        single_op = {{WIDTH{1'b0}}, lo};
      end
      CMD_XOR: single_op = {{WIDTH{1'b0}}, a ^ b};
      CMD_AND: single_op = {{WIDTH{1'b0}}, a & b};
      CMD_OR:  single_op = {{WIDTH{1'b0}}, a | b};
      default: single_op = '0;
    endcase
  endfunction

  always_comb sc_res = single_op(bus.cmd, bus.src0, bus.src1);

  assign idle_start = (state == ALU_SEQ_IDLE) & bus.start;
  assign mul_sum    = acc + (mplier[0] ? mcand : '0);
  assign mul_last   = (cnt == CNT_W'(1));
  assign div_start  = clk_oe & idle_start & (bus.cmd == CMD_DIV) & (|bus.src1);

  alu_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (clk_oe),
    .start     (div_start),
    .dividend  (bus.src0),
    .divisor   (bus.src1),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst)         state <= ALU_SEQ_IDLE;
    else if (clk_oe) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ALU_SEQ_IDLE: begin
        if (bus.start && bus.cmd == CMD_MUL)                 state_nxt = ALU_SEQ_MUL;
        else if (bus.start && bus.cmd == CMD_DIV && |bus.src1) state_nxt = ALU_SEQ_DIV;
      end
      ALU_SEQ_MUL: if (mul_last) state_nxt = ALU_SEQ_IDLE;
      ALU_SEQ_DIV: if (div_done) state_nxt = ALU_SEQ_IDLE;
      default:     state_nxt = ALU_SEQ_IDLE;
    endcase
  end

  // Result/flag registers: done defaults low every enabled edge, so it is a
  // one-interval strobe unless another completion lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_flag <= 1'b0;
      res_lo    <= '0;
      res_hi    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
    end else if (clk_oe) begin
      done_flag <= 1'b0;
      case (state)
        ALU_SEQ_IDLE: begin
          if (bus.start) begin
            if (is_single_cycle(bus.cmd)) begin
              res_lo    <= sc_res[WIDTH-1:0];
              res_hi    <= sc_res[2*WIDTH-1:WIDTH];
              zero      <= (sc_res[WIDTH-1:0] == '0);
              carry     <= ((bus.cmd == CMD_ADD) || (bus.cmd == CMD_SUB)) & sc_res[WIDTH];
              done_flag <= 1'b1;
            end else if (bus.cmd == CMD_MUL) begin
              cnt <= CNT_W'(WIDTH);
            end else if (bus.cmd == CMD_DIV) begin
              if (bus.src1 == '0) begin
                res_lo    <= '1;
                res_hi    <= bus.src0;
                zero      <= 1'b0;
                carry     <= 1'b0;
                dz        <= 1'b1;
                done_flag <= 1'b1;
              end
            end else begin
              done_flag <= 1'b1;
            end
          end
        end
        ALU_SEQ_MUL: begin
          cnt <= cnt - CNT_W'(1);
          if (mul_last) begin
            res_lo    <= mul_sum[WIDTH-1:0];
            res_hi    <= mul_sum[2*WIDTH-1:WIDTH];
            zero      <= (mul_sum[WIDTH-1:0] == '0);
            carry     <= 1'b0;
            done_flag <= 1'b1;
          end
        end
        ALU_SEQ_DIV: begin
          if (div_done) begin
            res_lo    <= div_quo;
            res_hi    <= div_rem;
            zero      <= (div_quo == '0);
            carry     <= 1'b0;
            dz        <= 1'b0;
            done_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Shift-add multiplier datapath; operands latched at acceptance.
  always_ff @(posedge clk) begin
    if (clk_oe) begin
      if (idle_start && bus.cmd == CMD_MUL) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, bus.src0};
        mplier <= bus.src1;
      end else if (state == ALU_SEQ_MUL) begin
        acc    <= mul_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  assign bus.busy     = (state != ALU_SEQ_IDLE);
  assign bus.done     = done_flag;
  assign bus.dst      = res_lo;
  assign bus.dst_h    = res_hi;
  assign bus.flag_z   = zero;
  assign bus.flag_c   = carry;
  assign bus.div_zero = dz;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clk_oe;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut  (.clk(clk), .rst(rst), .clk_oe(clk_oe), .bus(bus));
  alu_seq #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .clk_oe(clk_oe), .bus(bus8));

  int checks = 0;
  int errors = 0;

  logic [31:0] e_lo, e_hi;
  logic        e_z, e_c, e_dz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned wide;
    bit known;
    known = 1'b1;
    case (c)
      CMD_MOV: begin e_lo = a; e_hi = b; e_c = 1'b0; end
      CMD_ADD: begin
        wide = 64'(a) + 64'(b);
        e_lo = wide[31:0]; e_hi = wide[63:32];
        e_c  = (wide > 64'hFFFF_FFFF);
      end
      CMD_SUB: begin
        e_lo = a - b;
        e_hi = (a < b) ? 32'hFFFF_FFFF : 32'h0;
        e_c  = (a < b);
      end
      CMD_SHR: begin e_lo = (b >= 32) ? 32'h0 : (a >> b); e_hi = 0; e_c = 1'b0; end
      CMD_SHL: begin e_lo = (b >= 32) ? 32'h0 : (a << b); e_hi = 0; e_c = 1'b0; end
      CMD_XOR: begin e_lo = a ^ b; e_hi = 0; e_c = 1'b0; end
      CMD_AND: begin e_lo = a & b; e_hi = 0; e_c = 1'b0; end
      CMD_OR:  begin e_lo = a | b; e_hi = 0; e_c = 1'b0; end
      CMD_MUL: begin
        wide = 64'(a) * 64'(b);
        e_lo = wide[31:0]; e_hi = wide[63:32]; e_c = 1'b0;
      end
      CMD_DIV: begin
        e_c = 1'b0;
        if (b == 0) begin e_lo = 32'hFFFF_FFFF; e_hi = a; e_dz = 1'b1; end
        else begin e_lo = a / b; e_hi = a % b; e_dz = 1'b0; end
      end
      default: known = 1'b0;
    endcase
    if (known) e_z = (e_lo == 0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_done"},  64'(bus.done),     64'(1'b1));
    check({tag, "_busy"},  64'(bus.busy),     64'(1'b0));
    check({tag, "_dst"},   64'(bus.dst),      64'(e_lo));
    check({tag, "_dst_h"}, 64'(bus.dst_h),    64'(e_hi));
    check({tag, "_z"},     64'(bus.flag_z),   64'(e_z));
    check({tag, "_c"},     64'(bus.flag_c),   64'(e_c));
    check({tag, "_dz"},    64'(bus.div_zero), 64'(e_dz));
  endtask

  // Issue one op; for multi-cycle ops wait for done (optionally with clk_oe
  // toggling) and also pulse a competing start while busy.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit gate, input string tag);
    int  n;
    bit  multi;
    multi = (c == CMD_MUL) || (c == CMD_DIV && b != 0);
    bus.cmd = c; bus.src0 = a; bus.src1 = b; bus.start = 1'b1; clk_oe = 1'b1;
    tick();
    bus.start = 1'b0; bus.src0 = $urandom; bus.src1 = $urandom;
    model(c, a, b);
    if (multi) begin
      check({tag, "_busy_rise"}, 64'(bus.busy), 64'(1'b1));
      n = 0;
      for (int i = 0; i < 300; i++) begin
        clk_oe    = gate ? i[0] : 1'b1;
        bus.start = (i == 3);
        if (i == 3) begin bus.cmd = CMD_MUL; bus.src0 = 32'd5; bus.src1 = 32'd5; end
        tick();
        bus.start = 1'b0;
        if (clk_oe) n++;
        if (bus.done) break;
      end
      clk_oe = 1'b1;
      check({tag, "_latency"}, 64'(n), 64'd32);
    end
    check_outputs(tag);
  endtask

  initial begin
    int  n;
    bit  seen_done;
    logic [3:0]  rc;
    logic [31:0] ra, rb;

    bus.start = 0; bus.cmd = 0; bus.src0 = 0; bus.src1 = 0;
    bus8.start = 0; bus8.cmd = 0; bus8.src0 = 0; bus8.src1 = 0;
    e_lo = 0; e_hi = 0; e_z = 0; e_c = 0; e_dz = 0;

    // Reset applies even with clk_oe low
    rst = 1'b1; clk_oe = 1'b0;
    tick(); tick();
    rst = 1'b0; clk_oe = 1'b1;
    check("rst_busy", 64'(bus.busy), 64'(1'b0));
    check("rst_done", 64'(bus.done), 64'(1'b0));
    check("rst_dst",  64'(bus.dst),  64'h0);
    check("rst_dsth", 64'(bus.dst_h), 64'h0);
    check("rst_flags", 64'({bus.flag_z, bus.flag_c, bus.div_zero}), 64'h0);

    // Reset mid-MUL aborts with no done
    bus.cmd = CMD_MUL; bus.src0 = 32'hFFFF_FFFF; bus.src1 = 32'hFFFF_FFFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen_done = 1'b0;
    for (int i = 1; i < 10; i++) begin tick(); seen_done |= bus.done; end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); seen_done |= bus.done; end
    check("abort_busy", 64'(bus.busy), 64'(1'b0));
    check("abort_no_done", 64'(seen_done), 64'(1'b0));
    check("abort_dst", 64'({bus.dst, bus.dst_h}), 64'h0);
    check("abort_flags", 64'({bus.flag_z, bus.flag_c, bus.div_zero}), 64'h0);

    run_op(CMD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_full");
    check("mul_full_hi_const", 64'(bus.dst_h), 64'hFFFF_FFFE);
    run_op(CMD_DIV, 32'd100, 32'd7, 1'b0, "div_100_7");
    check("div_q_const", 64'(bus.dst), 64'd14);
    run_op(CMD_DIV, 32'd5, 32'd0, 1'b0, "div_by_0");
    check("div0_dz_const", 64'(bus.div_zero), 64'(1'b1));

    // Back-to-back single-cycle ops hold done high
    model(CMD_ADD, 32'hFFFF_FFFF, 32'd1);
    bus.cmd = CMD_ADD; bus.src0 = 32'hFFFF_FFFF; bus.src1 = 32'd1; bus.start = 1'b1;
    tick();
    check_outputs("add_wrap");
    model(CMD_SUB, 32'd3, 32'd5);
    bus.cmd = CMD_SUB; bus.src0 = 32'd3; bus.src1 = 32'd5;
    tick();
    bus.start = 1'b0;
    check_outputs("sub_b2b");
    check("sub_dst_const", 64'(bus.dst), 64'hFFFF_FFFE);

    // done holds across a disabled edge, clears at the next enabled one
    clk_oe = 1'b0; tick();
    check("done_hold_oe0", 64'(bus.done), 64'(1'b1));
    clk_oe = 1'b1; tick();
    check("done_clear", 64'(bus.done), 64'(1'b0));

    run_op(CMD_MUL, 32'd3, 32'd4, 1'b1, "mul_gated");
    check("mul_gated_const", 64'(bus.dst), 64'd12);
    run_op(CMD_SHL, 32'd1, 32'd31, 1'b0, "shl_31");
    run_op(CMD_SHR, 32'h8000_0000, 32'd32, 1'b0, "shr_32");
    run_op(4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "unknown_cmd");

    // Narrow build: 8-bit MUL completes in 8 enabled edges
    bus8.cmd = CMD_MUL; bus8.src0 = 8'hFF; bus8.src1 = 8'hFF; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick(); n++;
      if (bus8.done) break;
    end
    check("w8_latency", 64'(n), 64'd8);
    check("w8_dst_h", 64'(bus8.dst_h), 64'hFE);
    check("w8_dst", 64'(bus8.dst), 64'h01);

    // Randomized ops against the reference model
    for (int k = 0; k < 40; k++) begin
      rc = 4'($urandom_range(0, 11));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 40);
        1:       rb = 32'h0;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) ra = $urandom_range(0, 300);
      run_op(rc, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d_cmd%0h", k, rc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
